// File: rtl/associative_memory_seq.sv
// rtl/associative_memory_seq.sv - sequential nearest-prototype search over trained hypervectors
// One shared popcount scans the valid classes one per clock; result leaves over a valid/ready pair.
module associative_memory_seq #(
    parameter int HV_DIMENSION   = 64,
    parameter int CLASSES        = 16,
    parameter int LABEL_WIDTH    = 8,
    parameter int DISTANCE_WIDTH = 8
) (
    input  logic                      CLK_CI,
    input  logic                      Reset_RI,
    input  logic                      ValidIn_SI,
    output logic                      ReadyOut_SO,
    input  logic [1:0]                ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0]    LabelIn_DI,
    input  logic [HV_DIMENSION-1:0]   HypervectorIn_DI,
    output logic                      ValidOut_SO,
    input  logic                      ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0]    LabelOut_DO,
    output logic [DISTANCE_WIDTH-1:0] DistanceOut_DO,
    output logic                      NoMatch_SO
);

    localparam int IDX_W = (CLASSES > 1) ? $clog2(CLASSES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASSES - 1);
    localparam logic [LABEL_WIDTH:0] CLASS_LIMIT = (LABEL_WIDTH + 1)'(CLASSES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_OUTPUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [HV_DIMENSION-1:0]   r_mem [CLASSES];
    logic [CLASSES-1:0]        r_valid;
    logic [HV_DIMENSION-1:0]   r_query;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_found;
    logic [DISTANCE_WIDTH-1:0] r_best_d;
    logic [IDX_W-1:0]          r_best_label;
    logic [LABEL_WIDTH-1:0]    r_label_out;
    logic [DISTANCE_WIDTH-1:0] r_dist_out;
    logic                      r_nomatch;

    logic                      w_accept;
    logic                      w_in_range;
    logic [IDX_W-1:0]          w_label_idx;
    logic                      w_last;
    logic [HV_DIMENSION-1:0]   w_diff;
    logic [DISTANCE_WIDTH-1:0] w_dist;
    logic                      w_take;
    logic                      w_nb_found;
    logic [DISTANCE_WIDTH-1:0] w_nb_d;
    logic [IDX_W-1:0]          w_nb_label;

    // Gating with reset keeps the upstream from seeing a ready during the reset cycle itself.
    assign ReadyOut_SO    = (r_state == S_IDLE) && !Reset_RI;
    assign ValidOut_SO    = (r_state == S_OUTPUT);
    assign LabelOut_DO    = r_label_out;
    assign DistanceOut_DO = r_dist_out;
    assign NoMatch_SO     = r_nomatch;

    assign w_accept    = ValidIn_SI && ReadyOut_SO;
    assign w_in_range  = ({1'b0, LabelIn_DI} < CLASS_LIMIT);
    assign w_label_idx = LabelIn_DI[IDX_W-1:0];
    assign w_last      = (r_idx == LAST_IDX);
    assign w_diff      = r_mem[r_idx] ^ r_query;

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < HV_DIMENSION; i++) begin
            w_dist = w_dist + DISTANCE_WIDTH'(w_diff[i]);
        end
    end

    // Strict less-than: on equal distance the earlier (lower) index is kept.
    assign w_take     = r_valid[r_idx] && (!r_found || (w_dist < r_best_d));
    assign w_nb_found = r_found || w_take;
    assign w_nb_d     = w_take ? w_dist : r_best_d;
    assign w_nb_label = w_take ? r_idx : r_best_label;

    always_ff @(posedge CLK_CI) begin
        if (Reset_RI) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && (ModeIn_SI == 2'b00)) w_state_next = S_SEARCH;
            S_SEARCH: if (w_last) w_state_next = S_OUTPUT;
            S_OUTPUT: if (ReadyIn_SI) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_CI) begin
        if (Reset_RI) begin
            for (int i = 0; i < CLASSES; i++) begin
                r_mem[i] <= '0;
            end
            r_valid      <= '0;
            r_query      <= '0;
            r_idx        <= '0;
            r_found      <= 1'b0;
            r_best_d     <= '0;
            r_best_label <= '0;
            r_label_out  <= '0;
            r_dist_out   <= '0;
            r_nomatch    <= 1'b0;
        end else begin
            if (w_accept) begin
                case (ModeIn_SI)
                    2'b00: begin
                        r_query <= HypervectorIn_DI;
                        r_idx   <= '0;
                        r_found <= 1'b0;
                    end
                    2'b01: begin
                        if (w_in_range) begin
                            r_mem[w_label_idx]   <= HypervectorIn_DI;
                            r_valid[w_label_idx] <= 1'b1;
                        end
                    end
                    2'b10: begin
                        if (w_in_range) r_valid[w_label_idx] <= 1'b0;
                    end
                    default: r_valid <= '0;
                endcase
            end

            if (r_state == S_SEARCH) begin
                r_idx        <= r_idx + IDX_W'(1);
                r_found      <= w_nb_found;
                r_best_d     <= w_nb_d;
                r_best_label <= w_nb_label;
                // The last class is folded in directly, so results load on the final search edge.
                if (w_last) begin
                    if (w_nb_found) begin
                        r_label_out <= LABEL_WIDTH'(w_nb_label);
                        r_dist_out  <= w_nb_d;
                        r_nomatch   <= 1'b0;
                    end else begin
                        r_label_out <= '0;
                        r_dist_out  <= DISTANCE_WIDTH'(HV_DIMENSION);
                        r_nomatch   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_associative_memory_seq.sv
// tb/tb_associative_memory_seq.sv - randomized check of associative_memory_seq against a class-table model
module tb_associative_memory_seq;

    localparam int HV = 16;
    localparam int CL = 4;
    localparam int LW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic          rdy_out;
    logic [1:0]    mode = 2'b00;
    logic [LW-1:0] lin = '0;
    logic [HV-1:0] hin = '0;
    logic          vout;
    logic          rdy_in = 1'b0;
    logic [LW-1:0] lout;
    logic [DW-1:0] dout;
    logic          nomatch;

    int n_pass  = 0;
    int n_total = 0;

    logic [HV-1:0] m_mem   [CL];
    bit            m_valid [CL];

    associative_memory_seq #(
        .HV_DIMENSION   (HV),
        .CLASSES        (CL),
        .LABEL_WIDTH    (LW),
        .DISTANCE_WIDTH (DW)
    ) dut (
        .CLK_CI           (clk),
        .Reset_RI         (rst),
        .ValidIn_SI       (vin),
        .ReadyOut_SO      (rdy_out),
        .ModeIn_SI        (mode),
        .LabelIn_DI       (lin),
        .HypervectorIn_DI (hin),
        .ValidOut_SO      (vout),
        .ReadyIn_SI       (rdy_in),
        .LabelOut_DO      (lout),
        .DistanceOut_DO   (dout),
        .NoMatch_SO       (nomatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < CL; i++) begin
            m_mem[i]   = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic model_apply(input logic [1:0] md, input int lab, input logic [HV-1:0] hv);
        case (md)
            2'b01: if (lab < CL) begin
                m_mem[lab]   = hv;
                m_valid[lab] = 1'b1;
            end
            2'b10: if (lab < CL) m_valid[lab] = 1'b0;
            2'b11: for (int i = 0; i < CL; i++) m_valid[i] = 1'b0;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [1:0] md, input int lab, input logic [HV-1:0] hv);
        check("ready_before_req", rdy_out, 1);
        vin  = 1'b1;
        mode = md;
        lin  = lab[LW-1:0];
        hin  = hv;
        tick();
        vin = 1'b0;
        model_apply(md, lab, hv);
    endtask

    // Nearest valid prototype by plain search; lowest index kept on ties.
    task automatic expect_result(input logic [HV-1:0] q, input int stall);
        int n = 0;
        int best_d = HV;
        int best_l = 0;
        bit found = 1'b0;
        for (int i = 0; i < CL; i++) begin
            if (m_valid[i]) begin
                int d = $countones(m_mem[i] ^ q);
                if (!found || d < best_d) begin
                    best_d = d;
                    best_l = i;
                    found  = 1'b1;
                end
            end
        end
        while (!vout && n < 50) begin
            tick();
            n++;
        end
        check("latency", n, CL);
        check("label", lout, best_l);
        check("distance", dout, best_d);
        check("nomatch", nomatch, !found);
        // Upstream keeps offering a train while the result is stalled; it must be ignored.
        for (int s = 0; s < stall; s++) begin
            vin  = 1'b1;
            mode = 2'b01;
            lin  = 8'd1;
            hin  = q;
            tick();
            check("stall_valid", vout, 1);
            check("stall_ready", rdy_out, 0);
            check("stall_label", lout, best_l);
            check("stall_distance", dout, best_d);
            check("stall_nomatch", nomatch, !found);
        end
        vin    = 1'b0;
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check("valid_after_xfer", vout, 0);
        check("ready_after_xfer", rdy_out, 1);
        check("label_held", lout, best_l);
        check("distance_held", dout, best_d);
    endtask

    task automatic query(input logic [HV-1:0] q, input int stall);
        issue(2'b00, 0, q);
        expect_result(q, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", rdy_out, 0);
        check("rst_valid", vout, 0);
        check("rst_label", lout, 0);
        check("rst_distance", dout, 0);
        check("rst_nomatch", nomatch, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", rdy_out, 1);

        query(16'h1234, 0);

        issue(2'b01, 0, 16'h00FF);
        issue(2'b01, 2, 16'hFF00);
        query(16'h00FE, 0);

        issue(2'b11, 0, '0);
        issue(2'b01, 1, 16'h000F);
        issue(2'b01, 3, 16'h00F0);
        query(16'h0000, 0);

        issue(2'b11, 0, '0);
        issue(2'b01, 0, 16'h00FF);
        issue(2'b01, 2, 16'hFF00);
        issue(2'b10, 0, '0);
        query(16'h00FF, 0);
        issue(2'b01, 5, 16'h0F0F);
        query(16'h0F0F, 0);

        query(16'hAAAA, 5);
        query(16'hAAAA, 0);

        issue(2'b00, 0, 16'h1234);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        model_clear();
        check("abort_valid", vout, 0);
        check("abort_ready", rdy_out, 1);
        query(16'h1234, 0);

        for (int it = 0; it < 60; it++) begin
            int r = $urandom_range(0, 11);
            logic [HV-1:0] hv = HV'($urandom) & {HV{r[0]}} | HV'($urandom_range(0, 15));
            if (r <= 4) issue(2'b01, $urandom_range(0, 5), hv);
            else if (r == 5) issue(2'b10, $urandom_range(0, 5), '0);
            else if (r == 6 && $urandom_range(0, 2) == 0) issue(2'b11, 0, '0);
            else query(HV'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
